// File: rtl/regfile_pkg.sv
// Shared constants, types and the byte-merge helper for the multi-port register file.
// The merge helper operates on words up to MAX_DATA_W bits; callers cast to their width.
package regfile_pkg;

   localparam int RF_DATA_W  = 32;
   localparam int RF_DEPTH   = 32;
   localparam int ADDR_W     = $clog2(RF_DEPTH);
   localparam int STRB_W     = RF_DATA_W / 8;
   localparam int MAX_DATA_W = 128;
   localparam int MAX_STRB_W = MAX_DATA_W / 8;

   typedef logic [MAX_STRB_W-1:0] strb_t;
   typedef logic [MAX_DATA_W-1:0] word_t;

   // Bytes with a set strobe come from new_word; all others keep old_word.
   function automatic word_t merge_bytes(input word_t old_word, input word_t new_word,
                                         input strb_t strb);
      word_t merged;
      merged = old_word;
      for (int k = 0; k < MAX_STRB_W; k++) begin
         if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/regfile_cell.sv
// One register-file entry: DATA_W bits with per-byte write enables and synchronous clear.
module regfile_cell
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W
) (
   input  logic                clk_i,
   input  logic                clr_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      data_d = DATA_W'(merge_bytes(word_t'(data_q), word_t'(wdata_i), strb_t'(be_i)));
   end

   // Clear wins over any byte enable in the same cycle.
   always_ff @(posedge clk_i) begin
      if (clr_i) data_q <= '0;
      else       data_q <= data_d;
   end

   assign rdata_o = data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: combinational reads, byte-strobed synchronous write, optional zero entry.
// Define REGFILE_BYPASS_EN to forward a same-cycle write onto matching read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int DEPTH    = RF_DEPTH,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]  i_raddr,
   output logic [NUM_RD-1:0][DATA_W-1:0]         o_rdata,
   input  logic                                  i_wren,
   input  logic [$clog2(DEPTH)-1:0]              i_waddr,
   input  logic [DATA_W-1:0]                     i_wdata,
   input  logic [DATA_W/8-1:0]                   i_wstrb
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] entry [DEPTH];

   genvar e;
   for (e = 0; e < DEPTH; e++) begin : g_entry
      if (ZERO_REG != 0 && e == 0) begin : g_zero
         assign entry[e] = '0;
      end else begin : g_cell
         logic [DATA_W/8-1:0] be;
         assign be = (i_wren && i_waddr == AW'(e)) ? i_wstrb : '0;
         regfile_cell #(.DATA_W(DATA_W)) u_cell (
            .clk_i   (i_clk),
            .clr_i   (i_rst),
            .be_i    (be),
            .wdata_i (i_wdata),
            .rdata_o (entry[e])
         );
      end
   end

   genvar p;
   for (p = 0; p < NUM_RD; p++) begin : g_rd
      logic [DATA_W-1:0] stored;
      assign stored = entry[i_raddr[p]];
`ifdef REGFILE_BYPASS_EN
      // Forwarding never resurrects a discarded zero-entry write or a write lost to reset.
      logic fwd;
      assign fwd = i_wren && !i_rst && (i_raddr[p] == i_waddr)
                   && !(ZERO_REG != 0 && i_waddr == '0);
      assign o_rdata[p] = fwd
         ? DATA_W'(merge_bytes(word_t'(stored), word_t'(i_wdata), strb_t'(i_wstrb)))
         : stored;
`else
      assign o_rdata[p] = stored;
`endif
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 4-port zero-register instance and a 2-port plain instance
// share write and read-address stimulus; expectations are queued and checked on the falling edge.
module tb_regfile_mp;
   import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                    reset;
   logic [3:0][ADDR_W-1:0]  rdAddr;
   logic [3:0][31:0]        rdDataA;
   logic [1:0][31:0]        rdDataB;
   logic                    wren;
   logic [ADDR_W-1:0]       waddr;
   logic [31:0]             wdata;
   logic [STRB_W-1:0]       wstrb;

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(4), .ZERO_REG(1)) dutA (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_raddr (rdAddr),
      .o_rdata (rdDataA),
      .i_wren  (wren),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_wstrb (wstrb)
   );

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) dutB (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_raddr (rdAddr[1:0]),
      .o_rdata (rdDataB),
      .i_wren  (wren),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_wstrb (wstrb)
   );

   typedef struct {
      string       name;
      int          dutSel;
      int          port;
      logic [31:0] exp;
   } expect_t;

   expect_t sbQueue[$];
   int      checkCount = 0;
   int      errorCount = 0;

   // Monitor: every expectation queued during the cycle is compared mid-cycle.
   always @(negedge clock) begin
      expect_t     item;
      logic [31:0] act;
      while (sbQueue.size() > 0) begin
         item = sbQueue.pop_front();
         act  = (item.dutSel == 0) ? rdDataA[item.port] : rdDataB[item.port];
         checkCount++;
         if (act !== item.exp) begin
            errorCount++;
            $display("[TB] FAIL %s dut%0d port%0d: got %h, expected %h",
                     item.name, item.dutSel, item.port, act, item.exp);
         end
      end
   end

   task automatic applyStimulus(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                                input logic [31:0] wd, input logic [STRB_W-1:0] ws,
                                input logic [ADDR_W-1:0] ra);
      reset = rst;
      wren  = we;
      waddr = wa;
      wdata = wd;
      wstrb = ws;
      for (int i = 0; i < 4; i++) rdAddr[i] = ra;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expA, input logic [31:0] expB);
      expect_t item;
      for (int i = 0; i < 4; i++) begin
         item.name = name; item.dutSel = 0; item.port = i; item.exp = expA;
         sbQueue.push_back(item);
      end
      for (int i = 0; i < 2; i++) begin
         item.name = name; item.dutSel = 1; item.port = i; item.exp = expB;
         sbQueue.push_back(item);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, '0, '0, '0, '0);
      tick();
      tick();

      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, '0, ADDR_W'(a));
         checkOutput("reset_read", 32'h0, 32'h0);
         tick();
      end

      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5);
      checkOutput("wr5_full_same", BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h000000AA, 4'h1, 5'd5);
      checkOutput("wr5_byte_same", BYP ? 32'hDEADBEAA : 32'hDEADBEEF,
                  BYP ? 32'hDEADBEAA : 32'hDEADBEEF);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 5'd5);
      checkOutput("rd5_merged", 32'hDEADBEAA, 32'hDEADBEAA);
      tick();

      applyStimulus(1'b0, 1'b1, 5'd0, 32'h12345678, 4'hF, 5'd0);
      checkOutput("wr0_same", 32'h0, BYP ? 32'h12345678 : 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 5'd0);
      checkOutput("rd0", 32'h0, 32'h12345678);
      tick();

      applyStimulus(1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 5'd7);
      checkOutput("wr7_same", BYP ? 32'hCAFEF00D : 32'h0, BYP ? 32'hCAFEF00D : 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 5'd7);
      checkOutput("rd7", 32'hCAFEF00D, 32'hCAFEF00D);
      tick();

      applyStimulus(1'b0, 1'b1, 5'd7, 32'h11223344, 4'b1010, 5'd7);
      checkOutput("wr7_partial_same", BYP ? 32'h11FE330D : 32'hCAFEF00D,
                  BYP ? 32'h11FE330D : 32'hCAFEF00D);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 5'd7);
      checkOutput("rd7_partial", 32'h11FE330D, 32'h11FE330D);
      tick();

      applyStimulus(1'b0, 1'b1, 5'd9, 32'h0BADC0DE, 4'hF, 5'd0);
      checkOutput("wr9_rd0", 32'h0, 32'h12345678);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd9, 32'hFFFFFFFF, 4'h0, 5'd9);
      checkOutput("wr9_nostrb_same", 32'h0BADC0DE, 32'h0BADC0DE);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 5'd9);
      checkOutput("rd9_all_ports", 32'h0BADC0DE, 32'h0BADC0DE);
      tick();

      for (int a = 1; a < 32; a++) begin
         applyStimulus(1'b0, 1'b1, ADDR_W'(a), 32'h100 + 32'(a), 4'hF, 5'd0);
         checkOutput("fill_rd0", 32'h0, 32'h12345678);
         tick();
      end
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, '0, ADDR_W'(a));
         if (a == 0) checkOutput("fill_read", 32'h0, 32'h12345678);
         else        checkOutput("fill_read", 32'h100 + 32'(a), 32'h100 + 32'(a));
         tick();
      end

      applyStimulus(1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 4'hF, 5'd3);
      checkOutput("rst_wr3_same", 32'h103, 32'h103);
      tick();
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, '0, ADDR_W'(a));
         checkOutput("post_reset_read", 32'h0, 32'h0);
         tick();
      end

      applyStimulus(1'b1, 1'b1, 5'd4, 32'h00000044, 4'hF, 5'd4);
      checkOutput("rst_wr4_same", 32'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h00000055, 4'h1, 5'd4);
      checkOutput("resume_wr4_same", BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 5'd4);
      checkOutput("resume_rd4", 32'h55, 32'h55);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 5'd3);
      checkOutput("rd3_after_reset", 32'h0, 32'h0);
      tick();

      tick();
      if (sbQueue.size() > 0) begin
         $display("[TB] FAIL drain: got %0d pending, expected 0", sbQueue.size());
         errorCount += sbQueue.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
